// File: rtl/audio_pkg.sv
// Shared types for the audio serializer: framing mode and the stereo sample pair.
package audio_pkg;

  typedef enum logic {
    AUD_MODE_I2S = 1'b0,
    AUD_MODE_LJ  = 1'b1
  } aud_mode_t;

  localparam int AUD_DATA_WIDTH = 16;

  typedef struct packed {
    logic [AUD_DATA_WIDTH-1:0] left;
    logic [AUD_DATA_WIDTH-1:0] right;
  } aud_pair_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Small synchronous FIFO holding stereo sample pairs; push while full and pop while empty are ignored.
module audio_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S / left-justified transmitter: BCLK divider, frame bit counter and serializer fed by a sample FIFO.
import audio_pkg::*;

module audio_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  aud_mode_t                          mode,
  input  logic [DATA_WIDTH-1:0]              s_left,
  input  logic [DATA_WIDTH-1:0]              s_right,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underrun,
  output logic                               aud_bclk,
  output logic                               aud_lrck,
  output logic                               aud_dacdat
);

  localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] SLOT_C   = CNT_W'(SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0]        div_q;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    started;
  logic [2*DATA_WIDTH-1:0] frame_q;
  aud_mode_t               mode_q;
  logic                    delay_q;

  logic [2*DATA_WIDTH-1:0] fifo_data;
  logic                    fifo_full;
  logic                    fifo_empty;

  logic                    half_tick;
  logic                    fall_evt;
  logic                    frame_start;
  logic [CNT_W-1:0]        cnt_next;
  logic [CNT_W-1:0]        slot_k;
  logic                    slot_right;
  logic [2*DATA_WIDTH-1:0] frame_next;
  aud_mode_t               mode_next;
  logic [DATA_WIDTH-1:0]   sample;
  logic                    lj_bit;

  audio_sample_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data ({s_left, s_right}),
    .pop       (frame_start),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign s_ready = !fifo_full;

  // The first fall after enable must land on count 0, so the counter only advances once started.
  always_comb begin
    half_tick   = en && (div_q == DIV_LAST);
    fall_evt    = half_tick && aud_bclk;
    cnt_next    = (!started || bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
    frame_start = fall_evt && (cnt_next == '0);
    frame_next  = frame_start ? (fifo_empty ? '0 : fifo_data) : frame_q;
    mode_next   = frame_start ? mode : mode_q;
    slot_right  = (cnt_next >= SLOT_C);
    slot_k      = slot_right ? cnt_next - SLOT_C : cnt_next;
    sample      = slot_right ? frame_next[DATA_WIDTH-1:0] : frame_next[2*DATA_WIDTH-1:DATA_WIDTH];
    lj_bit      = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (slot_k == CNT_W'(i)) lj_bit = sample[DATA_WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      bit_cnt    <= '0;
      started    <= 1'b0;
      frame_q    <= '0;
      mode_q     <= AUD_MODE_I2S;
      delay_q    <= 1'b0;
      underrun   <= 1'b0;
      aud_bclk   <= 1'b0;
      aud_lrck   <= 1'b0;
      aud_dacdat <= 1'b0;
    end else if (!en) begin
      div_q      <= '0;
      bit_cnt    <= '0;
      started    <= 1'b0;
      delay_q    <= 1'b0;
      underrun   <= 1'b0;
      aud_bclk   <= 1'b0;
      aud_lrck   <= 1'b0;
      aud_dacdat <= 1'b0;
    end else begin
      underrun <= frame_start && fifo_empty;
      if (half_tick) begin
        div_q    <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (fall_evt) begin
        bit_cnt    <= cnt_next;
        started    <= 1'b1;
        frame_q    <= frame_next;
        mode_q     <= mode_next;
        aud_lrck   <= slot_right;
        delay_q    <= lj_bit;
        aud_dacdat <= (mode_next == AUD_MODE_LJ) ? lj_bit : delay_q;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: frame vectors from a table plus reset, FIFO-full and wide-slot sequences.
import audio_pkg::*;

module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        en32;
  aud_mode_t   mode;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        s_valid;
  logic        v32;

  logic        ready, underrun, bclk, lrck, dat;
  logic [2:0]  level;
  logic        ready32, u32, b32, l32, d32;
  logic [2:0]  level32;

  int cyc = 0;
  int under_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (underrun) under_cnt <= under_cnt + 1;

  audio_i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .BCLK_HALF(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(ready), .fifo_level(level), .underrun(underrun),
    .aud_bclk(bclk), .aud_lrck(lrck), .aud_dacdat(dat)
  );

  audio_i2s_tx #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .BCLK_HALF(2), .FIFO_DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .en(en32), .mode(mode), .s_left(s_left), .s_right(s_right),
    .s_valid(v32), .s_ready(ready32), .fifo_level(level32), .underrun(u32),
    .aud_bclk(b32), .aud_lrck(l32), .aud_dacdat(d32)
  );

  typedef struct {
    aud_mode_t   mode;
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  // Collects lrck/data at n consecutive BCLK falls; the first collected bit lands in bit n-1.
  task automatic capture(input bit sel, input int n, output logic [63:0] bits,
                         output logic [63:0] lr, output int t0, output int t1);
    logic p;
    int got;
    int waited;
    bits = '0; lr = '0; t0 = 0; t1 = 0; got = 0; waited = 0;
    p = sel ? b32 : bclk;
    while (got < n) begin
      @(negedge clk);
      waited++;
      if (p && !(sel ? b32 : bclk)) begin
        bits[n-1-got] = sel ? d32 : dat;
        lr[n-1-got]   = sel ? l32 : lrck;
        if (got == 0) t0 = cyc;
        if (got == 1) t1 = cyc;
        got++;
        waited = 0;
      end
      p = sel ? b32 : bclk;
      if (waited > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL fall_timeout: no BCLK fall for %0d cycles after %0d of %0d bits", waited, got, n);
        return;
      end
    end
  endtask

  initial begin
    logic [63:0] b1, b2, l1, l2;
    int t0, t1, f0, f1, ta, tb, u0;

    vecs[0] = '{AUD_MODE_LJ,  16'hA5C3, 16'h0F0F, 32'hA5C3_0F0F};
    vecs[1] = '{AUD_MODE_I2S, 16'hA5C3, 16'h0F0F, 32'hD2E1_8787};
    vecs[2] = '{AUD_MODE_I2S, 16'h1234, 16'h8001, 32'h891A_4000};
    vecs[3] = '{AUD_MODE_LJ,  16'h8000, 16'hFFFF, 32'h8000_FFFF};

    rst = 1'b1; en = 1'b0; en32 = 1'b0; mode = AUD_MODE_LJ;
    s_left = '0; s_right = '0; s_valid = 1'b0; v32 = 1'b0;
    f0 = 0; f1 = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrck", 64'(lrck), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    step();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) push(vecs[i].l, vecs[i].r);
    chk("full_level", 64'(level), 64'd4);
    chk("full_ready", 64'(ready), 64'd0);
    push(16'hDEAD, 16'hBEEF);
    chk("fifth_push_level", 64'(level), 64'd4);
    chk("idle_bclk", 64'(bclk), 64'd0);

    u0 = under_cnt;
    mode = vecs[0].mode;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bclk_before_rise", 64'(bclk), 64'd0);
    @(negedge clk);
    chk("bclk_first_rise", 64'(bclk), 64'd1);

    for (int i = 0; i < 4; i++) begin
      capture(1'b0, 16, b1, l1, ta, tb);
      if (i == 0) begin f0 = ta; t0 = ta; t1 = tb; end
      if (i == 1) f1 = ta;
      mode = (i < 3) ? vecs[i+1].mode : AUD_MODE_LJ;
      capture(1'b0, 16, b2, l2, ta, tb);
      chk($sformatf("frame%0d_dat", i), {32'h0, b1[15:0], b2[15:0]}, {32'h0, vecs[i].exp_dat});
      chk($sformatf("frame%0d_lrck", i), {32'h0, l1[15:0], l2[15:0]}, 64'h0000_FFFF);
    end
    chk("bclk_period", 64'(t1 - t0), 64'd4);
    chk("frame_period", 64'(f1 - f0), 64'd128);
    chk("no_early_underrun", 64'(under_cnt - u0), 64'd0);

    capture(1'b0, 32, b1, l1, ta, tb);
    chk("underrun_frame_dat", b1, 64'h0);
    chk("underrun_pulses", 64'(under_cnt - u0), 64'd1);

    step();
    en = 1'b0;
    step();
    push(16'h0020, 16'h1111);
    push(16'h2222, 16'h3333);
    push(16'h4444, 16'h5555);
    chk("pre_rst_level", 64'(level), 64'd3);
    mode = AUD_MODE_LJ;
    en = 1'b1;
    capture(1'b0, 11, b1, l1, ta, tb);
    chk("pre_rst_bits", b1, 64'h1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_bclk_high", 64'(bclk), 64'd1);
    chk("pre_rst_dat_high", 64'(dat), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_bclk", 64'(bclk), 64'd0);
    chk("mid_rst_lrck", 64'(lrck), 64'd0);
    chk("mid_rst_dat", 64'(dat), 64'd0);
    chk("mid_rst_underrun", 64'(underrun), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    u0 = under_cnt;
    step();
    step();
    rst = 1'b0;
    capture(1'b0, 32, b1, l1, ta, tb);
    chk("post_rst_dat", b1, 64'h0);
    chk("post_rst_lrck", l1, 64'h0000_FFFF);
    chk("post_rst_underrun", 64'(under_cnt - u0), 64'd1);
    chk("post_rst_level", 64'(level), 64'd0);

    step();
    en = 1'b0;
    s_left = 16'hFFFF;
    s_right = 16'hFFFF;
    v32 = 1'b1;
    step();
    v32 = 1'b0;
    chk("slot32_level", 64'(level32), 64'd1);
    chk("slot32_ready", 64'(ready32), 64'd1);
    mode = AUD_MODE_LJ;
    en32 = 1'b1;
    capture(1'b1, 64, b1, l1, ta, tb);
    chk("slot32_dat", b1, 64'hFFFF_0000_FFFF_0000);
    chk("slot32_lrck", l1, 64'h0000_0000_FFFF_FFFF);
    chk("slot32_no_underrun_yet", 64'(u32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample bits per channel.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: BCLK periods per channel slot; must be >= DATA_WIDTH.
REQ-003 SHALL have parameter BCLK_HALF, default 6: clk cycles per BCLK half-period; must be >= 1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: stereo sample-pair entries; power of two, >= 2.
REQ-005 SHALL have ports, in order:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  serializer enable.
- mode  in  audio_pkg::aud_mode_t  I2S or left-justified framing.
- s_left  in  DATA_WIDTH  left sample, two's complement.
- s_right  in  DATA_WIDTH  right sample.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  FIFO not full.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- underrun  out  1  one-cycle pulse, frame started with empty FIFO.
- aud_bclk  out  1  bit clock.
- aud_lrck  out  1  word select; 0 = left, 1 = right.
- aud_dacdat  out  1  serial data, MSB first.

Function
REQ-006 SHALL accept a pair when s_valid && s_ready at a clk edge; s_ready = (fifo_level != FIFO_DEPTH), combinational from count.
REQ-007 SHALL not accept a push while full, even if a pop occurs the same cycle; SHALL not bypass an empty FIFO on simultaneous push and pop.
REQ-008 With en=1, a divider SHALL count 0..BCLK_HALF-1 and toggle aud_bclk on the cycle it reaches BCLK_HALF-1, then wrap to 0.
REQ-009 "Fall event" = the clk edge where aud_bclk goes 1->0; aud_lrck and aud_dacdat SHALL update only on fall events, on that same clk edge.
REQ-010 A bit counter 0..2*SLOT_WIDTH-1 SHALL advance on each fall event and wrap to 0; aud_lrck SHALL be 0 for counts 0..SLOT_WIDTH-1 and 1 otherwise.
REQ-011 At the fall event where the count becomes 0 (frame start), the block SHALL pop one FIFO entry into the frame register and latch mode.
REQ-012 If the FIFO is empty at frame start, the frame register SHALL load all zeros and underrun SHALL pulse for exactly that one clk cycle.
REQ-013 Slot bit k (k = count mod SLOT_WIDTH) SHALL be sample bit DATA_WIDTH-1-k for k < DATA_WIDTH, else 0.
REQ-014 Left-justified mode: aud_dacdat SHALL present slot bit k during count k.
REQ-015 I2S mode: aud_dacdat SHALL present, during count k, the bit that left-justified mode presents during count k-1, via a one-bit delay flop. The last right-slot bit of a frame therefore appears during count 0 of the next frame.
REQ-016 A mode change SHALL take effect only at the next frame start.
REQ-017 When en=0, the block SHALL hold aud_bclk, aud_lrck and aud_dacdat at 0, hold the divider, bit counter and delay flop at 0, and not pop; pushes continue.
REQ-018 On en rising, the first BCLK rise SHALL occur BCLK_HALF cycles later, and the first fall event SHALL be a frame start.
REQ-019 Frame period SHALL be 4*SLOT_WIDTH*BCLK_HALF clk cycles.

Reset
REQ-020 While rst=1, the block SHALL asynchronously clear FIFO pointers and count, divider, bit counter, frame register and delay flop.
REQ-021 While rst=1, the block SHALL drive aud_bclk, aud_lrck, aud_dacdat, underrun and fifo_level to 0, and s_ready to 1.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame and all queued entries; after release, operation SHALL restart per REQ-018.

Structure
REQ-023 Package audio_pkg SHALL hold aud_mode_t (AUD_MODE_I2S = 0, AUD_MODE_LJ = 1) and a packed sample-pair struct parametrised by DATA_WIDTH via localparam.
REQ-024 The FIFO SHALL be a sub-module, audio_sample_fifo, with push/pop/full/empty/level ports; all framing logic SHALL stay in audio_i2s_tx.

Verification (DATA_WIDTH=16, SLOT_WIDTH=16, BCLK_HALF=2, FIFO_DEPTH=4 unless stated)
REQ-025 LJ, push L=16'hA5C3, R=16'h0F0F, then en=1 -> counts 0-15 carry A5C3 MSB first with lrck=0, counts 16-31 carry 0F0F with lrck=1; BCLK period 4 clk, frame 128 clk.
REQ-026 I2S, same data -> every bit delayed one BCLK versus REQ-025; count 0 of the second frame carries the LSB of 0F0F (1).
REQ-027 SLOT_WIDTH=32, LJ, L=16'hFFFF -> left counts 0-15 = 1, counts 16-31 = 0.
REQ-028 Push 4 pairs with en=0 -> s_ready=0 and fifo_level=4; a 5th s_valid is not accepted. Then en=1: after 4 frames the next frame start pulses underrun once and the frame outputs zeros.
REQ-029 Toggle mode mid-frame -> current frame framing unchanged; new framing starts at the next frame start.
REQ-030 Assert rst at count 10 with 3 entries queued -> all outputs 0 immediately, fifo_level=0, s_ready=1; after release, first output frame is underrun zeros.
